// File: rtl/iiq_pkg.sv
// Shared types and helpers for the unified integer issue queue.
// The entry layout and select helper are sized by the IIQ_* constants below.
package iiq_pkg;

   localparam int unsigned IIQ_DEPTH     = 8;
   localparam int unsigned IIQ_TAG_W     = 6;
   localparam int unsigned IIQ_PAYLOAD_W = 18;
   localparam int unsigned IIQ_NUM_WKP   = 3;
   localparam int unsigned IIQ_CNT_W     = $clog2(IIQ_DEPTH) + 1;

   typedef struct packed {
      logic                     valid;
      logic                     p0_only;
      logic [IIQ_TAG_W-1:0]     rs1_tag;
      logic [IIQ_TAG_W-1:0]     rs2_tag;
      logic                     rs1_rdy;
      logic                     rs2_rdy;
      logic [IIQ_PAYLOAD_W-1:0] payload;
   } iiq_entry_t;

   typedef logic [IIQ_DEPTH-1:0] iiq_vec_t;

   // One-hot grant of the oldest requester; age[j][i]=1 means j is older than i.
   function automatic iiq_vec_t iiq_oldest(input iiq_vec_t req,
                                           input iiq_vec_t [IIQ_DEPTH-1:0] age);
      iiq_vec_t grant;
      logic     blocked;
      grant = '0;
      for (int i = 0; i < int'(IIQ_DEPTH); i++) begin
         blocked = 1'b0;
         for (int j = 0; j < int'(IIQ_DEPTH); j++) begin
            if ((j != i) && req[j] && age[j][i]) blocked = 1'b1;
         end
         grant[i] = req[i] & ~blocked;
      end
      return grant;
   endfunction

endpackage

// File: rtl/iiq_age_select.sv
// Oldest-first arbiter: request vector plus age matrix to one-hot grant.
module iiq_age_select
   import iiq_pkg::*;
#(
   parameter int unsigned DEPTH = IIQ_DEPTH
)(
   input  logic [DEPTH-1:0]            i_req,
   input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
   output logic [DEPTH-1:0]            o_grant_c
);

   assign o_grant_c = iiq_oldest(i_req, i_age);

endmodule

// File: rtl/int_issue_queue.sv
// Unified integer issue queue: dual dispatch, tag wakeup, age-ordered dual issue.
// Define IIQ_WKP_BYPASS_EN to let same-cycle wakeups feed select directly.
module int_issue_queue
   import iiq_pkg::*;
#(
   parameter int unsigned DEPTH     = IIQ_DEPTH,
   parameter int unsigned TAG_W     = IIQ_TAG_W,
   parameter int unsigned PAYLOAD_W = IIQ_PAYLOAD_W,
   parameter int unsigned NUM_WKP   = IIQ_NUM_WKP
)(
   input  logic                     cpu_clock_i,
   input  logic                     cpu_reset_i,
   input  logic                     flush_i,
   input  logic                     d0_vld_i,
   input  logic [PAYLOAD_W-1:0]     d0_payload_i,
   input  logic [TAG_W-1:0]         d0_rs1_tag_i,
   input  logic [TAG_W-1:0]         d0_rs2_tag_i,
   input  logic                     d0_rs1_rdy_i,
   input  logic                     d0_rs2_rdy_i,
   input  logic                     d0_p0_only_i,
   output logic                     d0_busy_o,
   input  logic                     d1_vld_i,
   input  logic [PAYLOAD_W-1:0]     d1_payload_i,
   input  logic [TAG_W-1:0]         d1_rs1_tag_i,
   input  logic [TAG_W-1:0]         d1_rs2_tag_i,
   input  logic                     d1_rs1_rdy_i,
   input  logic                     d1_rs2_rdy_i,
   input  logic                     d1_p0_only_i,
   output logic                     d1_busy_o,
   input  logic [NUM_WKP-1:0]       wkp_vld_i,
   input  logic [NUM_WKP*TAG_W-1:0] wkp_tag_i,
   output logic                     i0_vld_o,
   output logic [PAYLOAD_W-1:0]     i0_payload_o,
   output logic                     i1_vld_o,
   output logic [PAYLOAD_W-1:0]     i1_payload_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   iiq_entry_t                  r_q [DEPTH];
   logic [DEPTH-1:0][DEPTH-1:0] r_age;
   logic [CNT_W-1:0]            r_count;
   logic                        r_busy;
   logic                        r_i0_vld;
   logic                        r_i1_vld;
   logic [PAYLOAD_W-1:0]        r_i0_payload;
   logic [PAYLOAD_W-1:0]        r_i1_payload;

   iiq_entry_t                  w_q_nxt [DEPTH];
   iiq_entry_t                  w_ent0;
   iiq_entry_t                  w_ent1;
   logic [DEPTH-1:0][DEPTH-1:0] w_age_nxt;
   logic [DEPTH-1:0]            w_valid;
   logic [DEPTH-1:0]            w_p0_only;
   logic [DEPTH-1:0]            w_hit1;
   logic [DEPTH-1:0]            w_hit2;
   logic [DEPTH-1:0]            w_rdy;
   logic [DEPTH-1:0]            w_req1;
   logic [DEPTH-1:0]            w_gnt0;
   logic [DEPTH-1:0]            w_gnt1;
   logic [DEPTH-1:0]            w_slot0;
   logic [DEPTH-1:0]            w_slot1;
   logic [DEPTH-1:0]            w_new0;
   logic [DEPTH-1:0]            w_new1;
   logic                        w_acc0;
   logic                        w_acc1;
   logic [PAYLOAD_W-1:0]        w_pay0;
   logic [PAYLOAD_W-1:0]        w_pay1;
   logic [CNT_W-1:0]            w_count_nxt;

   function automatic logic wkp_hit(input logic [TAG_W-1:0]         tag,
                                    input logic [NUM_WKP-1:0]       vld,
                                    input logic [NUM_WKP*TAG_W-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < int'(NUM_WKP); k++) begin
         if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Per-entry wakeup match and readiness seen by select.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_valid[i]   = r_q[i].valid;
         w_p0_only[i] = r_q[i].p0_only;
         w_hit1[i]    = wkp_hit(r_q[i].rs1_tag, wkp_vld_i, wkp_tag_i);
         w_hit2[i]    = wkp_hit(r_q[i].rs2_tag, wkp_vld_i, wkp_tag_i);
`ifdef IIQ_WKP_BYPASS_EN
         w_rdy[i]     = r_q[i].valid & (r_q[i].rs1_rdy | w_hit1[i])
                                     & (r_q[i].rs2_rdy | w_hit2[i]);
`else
         w_rdy[i]     = r_q[i].valid & r_q[i].rs1_rdy & r_q[i].rs2_rdy;
`endif
      end
   end

   iiq_age_select #(.DEPTH(DEPTH)) u_sel0 (
      .i_req     (w_rdy),
      .i_age     (r_age),
      .o_grant_c (w_gnt0)
   );

   // Port 1 cannot take port-0-only uops or port 0's pick.
   assign w_req1 = w_rdy & ~w_p0_only & ~w_gnt0;

   iiq_age_select #(.DEPTH(DEPTH)) u_sel1 (
      .i_req     (w_req1),
      .i_age     (r_age),
      .o_grant_c (w_gnt1)
   );

   // Two lowest free slots; entries issuing this cycle still count as occupied.
   always_comb begin
      w_slot0 = '0;
      w_slot1 = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!w_valid[i]) begin
            if (w_slot0 == '0)      w_slot0[i] = 1'b1;
            else if (w_slot1 == '0) w_slot1[i] = 1'b1;
         end
      end
   end

   assign w_acc0 = d0_vld_i & ~r_busy;
   assign w_acc1 = d1_vld_i & ~r_busy;
   assign w_new0 = w_slot0 & {DEPTH{w_acc0}};
   assign w_new1 = w_slot1 & {DEPTH{w_acc1}};

   always_comb begin
      w_ent0 = '{valid:   1'b1,
                 p0_only: d0_p0_only_i,
                 rs1_tag: d0_rs1_tag_i,
                 rs2_tag: d0_rs2_tag_i,
                 rs1_rdy: d0_rs1_rdy_i | wkp_hit(d0_rs1_tag_i, wkp_vld_i, wkp_tag_i),
                 rs2_rdy: d0_rs2_rdy_i | wkp_hit(d0_rs2_tag_i, wkp_vld_i, wkp_tag_i),
                 payload: d0_payload_i};
      w_ent1 = '{valid:   1'b1,
                 p0_only: d1_p0_only_i,
                 rs1_tag: d1_rs1_tag_i,
                 rs2_tag: d1_rs2_tag_i,
                 rs1_rdy: d1_rs1_rdy_i | wkp_hit(d1_rs1_tag_i, wkp_vld_i, wkp_tag_i),
                 rs2_rdy: d1_rs2_rdy_i | wkp_hit(d1_rs2_tag_i, wkp_vld_i, wkp_tag_i),
                 payload: d1_payload_i};
   end

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_q_nxt[i] = r_q[i];
         if (r_q[i].valid) begin
            w_q_nxt[i].rs1_rdy = r_q[i].rs1_rdy | w_hit1[i];
            w_q_nxt[i].rs2_rdy = r_q[i].rs2_rdy | w_hit2[i];
         end
         if (w_gnt0[i] | w_gnt1[i]) w_q_nxt[i].valid = 1'b0;
         if (w_new0[i]) w_q_nxt[i] = w_ent0;
         if (w_new1[i]) w_q_nxt[i] = w_ent1;
      end
   end

   // Freed columns clear; new rows start empty; d0 is older than a same-cycle d1.
   always_comb begin
      w_age_nxt = r_age;
      for (int i = 0; i < int'(DEPTH); i++) begin
         for (int j = 0; j < int'(DEPTH); j++) begin
            if (w_gnt0[j] | w_gnt1[j]) w_age_nxt[i][j] = 1'b0;
            if (w_new0[j] | w_new1[j]) w_age_nxt[i][j] = w_valid[i];
            if (w_new0[i])             w_age_nxt[i][j] = w_new1[j];
            else if (w_new1[i])        w_age_nxt[i][j] = 1'b0;
         end
      end
   end

   always_comb begin
      w_pay0 = '0;
      w_pay1 = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (w_gnt0[i]) w_pay0 = w_pay0 | r_q[i].payload;
         if (w_gnt1[i]) w_pay1 = w_pay1 | r_q[i].payload;
      end
   end

   assign w_count_nxt = r_count + CNT_W'(w_acc0) + CNT_W'(w_acc1)
                      - CNT_W'(|w_gnt0) - CNT_W'(|w_gnt1);

   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= '0;
         r_age        <= '0;
         r_count      <= '0;
         r_busy       <= 1'b0;
         r_i0_vld     <= 1'b0;
         r_i1_vld     <= 1'b0;
         r_i0_payload <= '0;
         r_i1_payload <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < int'(DEPTH); i++) r_q[i].valid <= 1'b0;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_i0_vld <= 1'b0;
         r_i1_vld <= 1'b0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= w_q_nxt[i];
         r_age        <= w_age_nxt;
         r_count      <= w_count_nxt;
         r_busy       <= (w_count_nxt >= CNT_W'(DEPTH - 1));
         r_i0_vld     <= |w_gnt0;
         r_i1_vld     <= |w_gnt1;
         r_i0_payload <= w_pay0;
         r_i1_payload <= w_pay1;
      end
   end

   assign d0_busy_o    = r_busy;
   assign d1_busy_o    = r_busy;
   assign i0_vld_o     = r_i0_vld;
   assign i1_vld_o     = r_i1_vld;
   assign i0_payload_o = r_i0_payload;
   assign i1_payload_o = r_i1_payload;
   assign count_o      = r_count;

endmodule
